// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters,
// with a single registered response slot and a saturating drain counter.
module alu_share_arbiter #(
    parameter int unsigned ALU_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ALU_WIDTH-1:0] req0_op1,
    input  logic [ALU_WIDTH-1:0] req0_op2,
    input  logic [3:0]           req0_alu_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ALU_WIDTH-1:0] req1_op1,
    input  logic [ALU_WIDTH-1:0] req1_op2,
    input  logic [3:0]           req1_alu_op,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [ALU_WIDTH-1:0] rsp_result,
    output logic [ALU_WIDTH-1:0] alu_op1,
    output logic [ALU_WIDTH-1:0] alu_op2,
    output logic [3:0]           alu_alu_op,
    input  logic [ALU_WIDTH-1:0] alu_result,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   owner_ready;
    logic   can_accept;
    logic   grant0;
    logic   grant1;
    logic   accept;
    logic   drain;

    // Slot is free when empty or when the current owner drains this cycle.
    always_comb begin
        owner_ready = owner ? rsp1_ready : rsp0_ready;
        can_accept  = (state == EMPTY) || owner_ready;
        drain       = (state == HOLD) && owner_ready;
        grant0      = 1'b0;
        grant1      = 1'b0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        accept = grant0 || grant1;
    end

    always_comb begin
        alu_op1    = '0;
        alu_op2    = '0;
        alu_alu_op = 4'd0;
        if (grant0) begin
            alu_op1    = req0_op1;
            alu_op2    = req0_op2;
            alu_alu_op = req0_alu_op;
        end else if (grant1) begin
            alu_op1    = req1_op1;
            alu_op2    = req1_op2;
            alu_alu_op = req1_alu_op;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (state == HOLD) && !owner;
    assign rsp1_valid = (state == HOLD) && owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_result <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                state      <= HOLD;
                owner      <= grant1;
                last_grant <= grant1;
                rsp_result <= alu_result;
            end else if (drain) begin
                state <= EMPTY;
            end
            if (drain && (op_count != CNT_MAX)) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
